// File: rtl/cpu_fetch_unit_if.sv
// Fetch-stage bus: redirect/stall/halt controls in, instruction-memory read port
// and decode-slot status out.
interface cpu_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic              i_de_jump_i;
  logic [ADDR_W-1:0] i_de_target;
  logic              i_ex_jump_r;
  logic [ADDR_W-1:0] i_ex_target;
  logic              i_stall;
  logic              i_halt;
  logic              o_pc_rd;
  logic [ADDR_W-1:0] o_pc_addr;
  logic [1:0]        o_pc_addr_sel;
  logic              o_de_valid;
  logic [ADDR_W-1:0] o_de_pc;
  logic [ADDR_W-1:0] o_de_link;
  logic [CNT_W-1:0]  o_redirect_cnt;
  logic [CNT_W-1:0]  o_squash_cnt;

  modport master (
    input  i_de_jump_i, i_de_target, i_ex_jump_r, i_ex_target, i_stall, i_halt,
    output o_pc_rd, o_pc_addr, o_pc_addr_sel, o_de_valid, o_de_pc, o_de_link,
           o_redirect_cnt, o_squash_cnt
  );

  modport slave (
    output i_de_jump_i, i_de_target, i_ex_jump_r, i_ex_target, i_stall, i_halt,
    input  o_pc_rd, o_pc_addr, o_pc_addr_sel, o_de_valid, o_de_pc, o_de_link,
           o_redirect_cnt, o_squash_cnt
  );
endinterface

// File: rtl/cpu_fetch_unit.sv
// Fetch stage: owns the PC, drives the synchronous instruction-memory read port
// and tracks whether the instruction presented to decode is on the right path.
//
//   state  | meaning
//   S_BOOT | first cycle after reset, fetch RESET_PC, all controls ignored
//   S_RUN  | normal fetch: reg jump > imm jump > halt > stall > sequential
//   S_HALT | fetch stopped, decode slot empty, left only through reset
module cpu_fetch_unit #(
  parameter int                 ADDR_W      = 16,
  parameter int                 INSTR_BYTES = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  cpu_fetch_unit_if.master  fif
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INSTR_BYTES);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              v_q, v_d;
  logic [CNT_W-1:0]  redirect_cnt_q, redirect_cnt_d;
  logic [CNT_W-1:0]  squash_cnt_q, squash_cnt_d;

  logic              pc_rd;
  logic [ADDR_W-1:0] pc_addr;
  logic [1:0]        pc_addr_sel;
  logic              de_valid;
  logic              squash;

  always_comb begin
    state_d     = state_q;
    pc_rd       = 1'b0;
    pc_addr     = pc_q;
    pc_addr_sel = 2'd0;
    de_valid    = 1'b0;
    squash      = 1'b0;

    if (reset) begin
      pc_addr = RESET_PC;
    end else begin
      case (state_q)
        S_BOOT: begin
          pc_rd   = 1'b1;
          pc_addr = RESET_PC;
          state_d = S_RUN;
        end
        S_RUN: begin
          pc_rd    = 1'b1;
          de_valid = v_q & ~fif.i_ex_jump_r;
          squash   = v_q & fif.i_ex_jump_r;
          if (fif.i_ex_jump_r) begin
            pc_addr     = fif.i_ex_target;
            pc_addr_sel = 2'd2;
          end else if (fif.i_de_jump_i && v_q) begin
            pc_addr     = fif.i_de_target;
            pc_addr_sel = 2'd1;
          end else if (fif.i_halt && v_q) begin
            pc_rd   = 1'b0;
            state_d = S_HALT;
          end else if (fif.i_stall) begin
            pc_addr = pc_q;
          end else begin
            pc_addr = pc_q + STEP;
          end
        end
        default: begin
          pc_rd = 1'b0;
        end
      endcase
    end

    // The slot is valid exactly when the previous cycle issued a read.
    pc_d = pc_rd ? pc_addr : pc_q;
    v_d  = pc_rd;

    redirect_cnt_d = redirect_cnt_q;
    if (pc_addr_sel != 2'd0 && redirect_cnt_q != CNT_MAX)
      redirect_cnt_d = redirect_cnt_q + 1'b1;

    squash_cnt_d = squash_cnt_q;
    if (squash && squash_cnt_q != CNT_MAX)
      squash_cnt_d = squash_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_BOOT;
      pc_q           <= RESET_PC;
      v_q            <= 1'b0;
      redirect_cnt_q <= '0;
      squash_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      v_q            <= v_d;
      redirect_cnt_q <= redirect_cnt_d;
      squash_cnt_q   <= squash_cnt_d;
    end
  end

  assign fif.o_pc_rd        = pc_rd;
  assign fif.o_pc_addr      = pc_addr;
  assign fif.o_pc_addr_sel  = pc_addr_sel;
  assign fif.o_de_valid     = de_valid;
  assign fif.o_de_pc        = pc_q;
  assign fif.o_de_link      = pc_q + STEP;
  assign fif.o_redirect_cnt = redirect_cnt_q;
  assign fif.o_squash_cnt   = squash_cnt_q;

endmodule
